tlp_vc_arbiter: RTL and testbench
=================================

# tlp_vc_arbiter

Controller and round-robin arbiter sitting between the per-virtual-channel transaction-layer FIFOs and the shared downstream path. It sequences the FIFOs through reset and threshold configuration, then pops at most one word per cycle from an eligible VC and forwards it with its VC tag. Eligibility depends on FIFO emptiness and per-VC downstream backpressure.

## Interface
- NUM_VC, 4, number of virtual-channel FIFOs (power of two, ≥2)
- DATA_W, 10, FIFO word width
- TH_W, 3, threshold width
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- init  in  1  request (re)configuration; level
- umbral_sup_in  in  TH_W  almost-full threshold to program
- umbral_inf_in  in  TH_W  almost-empty threshold to program
- fifo_empty  in  NUM_VC  per-VC FIFO has no data
- fifo_data  in  NUM_VC*DATA_W  per-VC FIFO read data, VC i at bits [i*DATA_W +: DATA_W]
- dest_almost_full  in  NUM_VC  per-VC downstream backpressure
- fifo_state  out  1  FIFO enable; 0 holds FIFOs cleared
- umbral_superior, umbral_inferior  out  TH_W  registered thresholds to FIFOs
- fifo_pop  out  NUM_VC  one-hot-or-zero pop
- out_push  out  1  out_data/out_vc valid
- out_data  out  DATA_W  forwarded word
- out_vc  out  log2(NUM_VC)  VC of out_data
- fsm_state  out  2  current state
- idle  out  1  IDLE and all FIFOs empty

## Operation
- States: RESET=0, INIT=1, IDLE=2, ACTIVE=3.
- RESET: entered while reset=1; leaves unconditionally to INIT on the first cycle with reset=0.
- INIT: umbral_superior/inferior load umbral_sup_in/inf_in every cycle. Stays while init=1. Goes to IDLE when init=0.
- IDLE/ACTIVE: next state is ACTIVE if any VC is eligible, else IDLE. init=1 in either state goes to INIT.
- fifo_state=0 in RESET and INIT, 1 otherwise. Thresholds are stable whenever fifo_state falls.
- Eligible VC i: !fifo_empty[i] && !dest_almost_full[i].
- Grant is computed combinationally in IDLE/ACTIVE from current inputs. Search starts at rr_ptr+1 mod NUM_VC and wraps. The first eligible VC gets fifo_pop[i]=1.
- rr_ptr updates to the granted VC on each grant. It holds when there is no grant.
- No pops in RESET/INIT.
- Pop-to-push pipeline:
  - the granted index and a valid bit are registered;
  - next cycle, out_push=valid, out_vc=index, out_data=fifo_data slice of index (mux).
- Arithmetic: rr_ptr is log2(NUM_VC) bits and wraps naturally.

## Timing
- Reset values:
  - fsm_state=RESET, fifo_state=0, thresholds 0;
  - fifo_pop=0, out_push=0, out_data=0, out_vc=0;
  - idle=0, rr_ptr=NUM_VC-1, so VC0 is searched first.
- Pop asserted in cycle N means out_push in N+1. FIFO read data is valid the cycle after pop.
- Throughput is one word per cycle, sustained while eligible VCs exist.
- A VC whose dest_almost_full rises in cycle N is not granted in N. A grant already issued in N-1 still pushes in N.
- Simultaneous init=1 and a pending pipeline valid: the push is suppressed (out_push=0) and the word is discarded, because the FIFOs are being cleared.
- Reset mid-operation: all outputs take reset values on the next edge and in-flight data is dropped.
- An empty FIFO is never popped, even if it is the round-robin next.

## Configuration
- VC_STRICT_PRIO_EN defined: fixed priority, lowest index wins. rr_ptr is unused and held at reset value.
- VC_STRICT_PRIO_EN undefined: round-robin as above (default).

## Structure
- Shared package tlp_pkg:
  - state encoding constants;
  - DATA_W/TH_W defaults;
  - VC index typedef.
- One sub-module, tlp_rr_pick: combinational rotate-priority picker (request vector + start pointer → one-hot grant + index). The strict-priority variant is start pointer fixed to 0.

## Test plan
- Reset release with init=0 → fsm_state goes 0→1→2 on consecutive cycles. fifo_state=1 from the IDLE cycle onward. Thresholds equal inputs sampled in INIT.
- All four VCs non-empty, no backpressure, 8 cycles:
  - pops rotate VC0,1,2,3,0,1,2,3;
  - out_vc follows one cycle later, out_push continuous.
- VC1 dest_almost_full=1, VC0/1/2 non-empty → grants alternate VC0,VC2 and VC1 is never popped.
- Only VC3 non-empty with one word; fifo_empty[3] rises after the pop → exactly one out_push with VC3 data. fsm_state returns to IDLE and idle=1.
- init=1 during ACTIVE with a pop issued the same cycle → next cycle out_push=0, fifo_state=0, thresholds reload (e.g. 6/2). Returns to IDLE when init drops.
- With VC_STRICT_PRIO_EN, VC0 and VC2 non-empty → VC0 is granted every cycle until empty, then VC2.

Source files
------------

// File: rtl/tlp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tlp_pkg : shared state encoding, width defaults and VC index type    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package tlp_pkg;

    localparam int DEF_NUM_VC = 4;
    localparam int DEF_DATA_W = 10;
    localparam int DEF_TH_W   = 3;
    localparam int VC_IDX_W   = $clog2(DEF_NUM_VC);

    typedef logic [VC_IDX_W-1:0] vc_idx_t;

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_INIT   = 2'd1,
        ST_IDLE   = 2'd2,
        ST_ACTIVE = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/tlp_vc_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tlp_vc_arbiter_if : per-VC FIFO side and downstream push bus         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface tlp_vc_arbiter_if
    import tlp_pkg::*;
#(
    parameter int NUM_VC = DEF_NUM_VC,
    parameter int DATA_W = DEF_DATA_W
) ();

    logic [NUM_VC-1:0]         fifo_empty;
    logic [NUM_VC*DATA_W-1:0]  fifo_data;
    logic [NUM_VC-1:0]         dest_almost_full;
    logic [NUM_VC-1:0]         fifo_pop;
    logic                      out_push;
    logic [DATA_W-1:0]         out_data;
    logic [$clog2(NUM_VC)-1:0] out_vc;

    // master: the arbiter; slave: FIFOs and downstream path
    modport master (
        input  fifo_empty, fifo_data, dest_almost_full,
        output fifo_pop, out_push, out_data, out_vc
    );

    modport slave (
        output fifo_empty, fifo_data, dest_almost_full,
        input  fifo_pop, out_push, out_data, out_vc
    );

endinterface
`default_nettype wire

// File: rtl/tlp_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tlp_rr_pick : rotate-priority picker, search begins at start index   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tlp_rr_pick
    import tlp_pkg::*;
#(
    parameter int N  = DEF_NUM_VC,
    parameter int IW = $clog2(N)
) (
    input  wire logic [N-1:0]  req,
    input  wire logic [IW-1:0] start,
    output logic      [N-1:0]  grant,
    output logic      [IW-1:0] idx,
    output logic               any
);

    logic [IW-1:0] w_cand;

    // N is a power of two, so the IW-bit add wraps the search naturally
    always_comb begin
        any    = 1'b0;
        idx    = '0;
        w_cand = '0;
        for (int k = 0; k < N; k++) begin
            w_cand = start + IW'(k);
            if (!any && req[w_cand]) begin
                any = 1'b1;
                idx = w_cand;
            end
        end
        grant = any ? (N'(1) << idx) : '0;
    end

endmodule
`default_nettype wire

// File: rtl/tlp_vc_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tlp_vc_arbiter : VC FIFO sequencer + one-word-per-cycle arbiter      |
// | Option macro VC_STRICT_PRIO_EN selects fixed lowest-index priority.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tlp_vc_arbiter
    import tlp_pkg::*;
#(
    parameter int NUM_VC = DEF_NUM_VC,
    parameter int DATA_W = DEF_DATA_W,
    parameter int TH_W   = DEF_TH_W
) (
    input  wire logic            clk,
    input  wire logic            reset,
    input  wire logic            init,
    input  wire logic [TH_W-1:0] umbral_sup_in,
    input  wire logic [TH_W-1:0] umbral_inf_in,
    tlp_vc_arbiter_if.master     bus,
    output logic                 fifo_state,
    output logic      [TH_W-1:0] umbral_superior,
    output logic      [TH_W-1:0] umbral_inferior,
    output logic      [1:0]      fsm_state,
    output logic                 idle
);

    localparam int IW = $clog2(NUM_VC);

    state_t              r_state;
    state_t              w_next;
    logic [IW-1:0]       r_rr_ptr;
    logic [IW-1:0]       r_idx;
    logic                r_valid;
    logic [TH_W-1:0]     r_sup;
    logic [TH_W-1:0]     r_inf;
    logic [IW-1:0]       w_start;
    logic [IW-1:0]       w_pick_idx;
    logic [NUM_VC-1:0]   w_pick_oh;
    logic [NUM_VC-1:0]   w_elig;
    logic                w_pick_any;
    logic                w_arb_en;
    logic                w_grant;
    logic [DATA_W-1:0]   w_rd_word;

    assign w_elig   = ~bus.fifo_empty & ~bus.dest_almost_full;
    assign w_arb_en = (r_state == ST_IDLE) || (r_state == ST_ACTIVE);

`ifdef VC_STRICT_PRIO_EN
    assign w_start = '0;
`else
    assign w_start = r_rr_ptr + IW'(1);
`endif

    tlp_rr_pick #(
        .N  (NUM_VC),
        .IW (IW)
    ) u_pick (
        .req   (w_elig),
        .start (w_start),
        .grant (w_pick_oh),
        .idx   (w_pick_idx),
        .any   (w_pick_any)
    );

    assign w_grant = w_arb_en && w_pick_any;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_RESET;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_RESET:  w_next = ST_INIT;
            ST_INIT:   w_next = init ? ST_INIT : ST_IDLE;
            ST_IDLE,
            ST_ACTIVE: begin
                if (init)
                    w_next = ST_INIT;
                else if (|w_elig)
                    w_next = ST_ACTIVE;
                else
                    w_next = ST_IDLE;
            end
            default:   w_next = ST_RESET;
        endcase
    end

    // A pop taken while init is high is dropped: the FIFOs are about to be cleared
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid  <= 1'b0;
            r_idx    <= '0;
            r_rr_ptr <= '1;
            r_sup    <= '0;
            r_inf    <= '0;
        end else begin
            r_valid <= w_grant && !init;
            if (w_grant) begin
                r_idx <= w_pick_idx;
`ifndef VC_STRICT_PRIO_EN
                r_rr_ptr <= w_pick_idx;
`endif
            end
            if (r_state == ST_INIT) begin
                r_sup <= umbral_sup_in;
                r_inf <= umbral_inf_in;
            end
        end
    end

    assign w_rd_word = bus.fifo_data[r_idx*DATA_W +: DATA_W];

    assign bus.fifo_pop = w_grant ? w_pick_oh : '0;
    assign bus.out_push = r_valid && !init;
    assign bus.out_data = bus.out_push ? w_rd_word : '0;
    assign bus.out_vc   = r_idx;

    assign fifo_state      = w_arb_en;
    assign umbral_superior = r_sup;
    assign umbral_inferior = r_inf;
    assign fsm_state       = r_state;
    assign idle            = (r_state == ST_IDLE) && (&bus.fifo_empty);

endmodule
`default_nettype wire

// File: tb/tb_tlp_vc_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_tlp_vc_arbiter : directed self-checking bench for tlp_vc_arbiter  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_tlp_vc_arbiter;
    import tlp_pkg::*;

    logic       clk;
    logic       reset;
    logic       init;
    logic [2:0] umbral_sup_in;
    logic [2:0] umbral_inf_in;
    logic       fifo_state;
    logic [2:0] umbral_superior;
    logic [2:0] umbral_inferior;
    logic [1:0] fsm_state;
    logic       idle;

    int n_tests = 0;
    int n_fail  = 0;

    logic [9:0] dat [4];

    tlp_vc_arbiter_if #(.NUM_VC(4), .DATA_W(10)) bus ();

    tlp_vc_arbiter #(
        .NUM_VC (4),
        .DATA_W (10),
        .TH_W   (3)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .init            (init),
        .umbral_sup_in   (umbral_sup_in),
        .umbral_inf_in   (umbral_inf_in),
        .bus             (bus.master),
        .fifo_state      (fifo_state),
        .umbral_superior (umbral_superior),
        .umbral_inferior (umbral_inferior),
        .fsm_state       (fsm_state),
        .idle            (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_push(input string tag, input int vc);
        check({tag, "_push"}, 32'(bus.out_push), 32'd1);
        check({tag, "_vc"},   32'(bus.out_vc),   32'(vc));
        check({tag, "_data"}, 32'(bus.out_data), 32'(dat[vc]));
    endtask

`ifdef VC_STRICT_PRIO_EN
    localparam logic [3:0] INIT_POP_B  = 4'b0001;
    localparam logic [3:0] RST_POP     = 4'b0001;
    localparam int         RST_VC      = 0;
`else
    localparam logic [3:0] INIT_POP_B  = 4'b0010;
    localparam logic [3:0] RST_POP     = 4'b0100;
    localparam int         RST_VC      = 2;
`endif

    initial begin
        dat[0] = 10'h2A1;
        dat[1] = 10'h1B2;
        dat[2] = 10'h0C3;
        dat[3] = 10'h3D4;
        reset = 1'b1;
        init  = 1'b0;
        umbral_sup_in = 3'd5;
        umbral_inf_in = 3'd1;
        bus.fifo_empty       = 4'hF;
        bus.dest_almost_full = 4'h0;
        bus.fifo_data        = {dat[3], dat[2], dat[1], dat[0]};
        repeat (3) @(posedge clk);

        // reset values
        @(negedge clk); #1;
        check("rst_state", 32'(fsm_state), 32'(ST_RESET));
        check("rst_fifo_state", 32'(fifo_state), 32'd0);
        check("rst_sup", 32'(umbral_superior), 32'd0);
        check("rst_inf", 32'(umbral_inferior), 32'd0);
        check("rst_pop", 32'(bus.fifo_pop), 32'd0);
        check("rst_push", 32'(bus.out_push), 32'd0);
        check("rst_data", 32'(bus.out_data), 32'd0);
        check("rst_vc", 32'(bus.out_vc), 32'd0);
        check("rst_idle", 32'(idle), 32'd0);

        // release: RESET -> INIT -> IDLE
        @(negedge clk); reset = 1'b0; #1;
        check("rel_state0", 32'(fsm_state), 32'(ST_RESET));
        @(negedge clk); #1;
        check("rel_state1", 32'(fsm_state), 32'(ST_INIT));
        check("rel_fs1", 32'(fifo_state), 32'd0);
        @(negedge clk); #1;
        check("rel_state2", 32'(fsm_state), 32'(ST_IDLE));
        check("rel_fs2", 32'(fifo_state), 32'd1);
        check("rel_sup", 32'(umbral_superior), 32'd5);
        check("rel_inf", 32'(umbral_inferior), 32'd1);
        check("rel_idle", 32'(idle), 32'd1);

`ifdef VC_STRICT_PRIO_EN
        // VC0 and VC2 loaded: VC0 wins until it drains, then VC2
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            bus.fifo_empty = (k < 3) ? 4'b1010 : ((k < 5) ? 4'b1011 : 4'b1111);
            #1;
            check("sp_pop", 32'(bus.fifo_pop), (k < 3) ? 32'h1 : ((k < 5) ? 32'h4 : 32'h0));
            if (k == 0) check("sp_push0", 32'(bus.out_push), 32'd0);
            else        check_push("sp", (k < 4) ? 0 : 2);
        end
        @(negedge clk); #1;
        check("sp_idle_push", 32'(bus.out_push), 32'd0);
        check("sp_idle", 32'(idle), 32'd1);
`else
        // all VCs loaded: rotation 0,1,2,3,0,1,2,3 with pushes one cycle later
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            bus.fifo_empty = (k < 8) ? 4'h0 : 4'hF;
            #1;
            check("rr_pop", 32'(bus.fifo_pop), (k < 8) ? (32'd1 << (k % 4)) : 32'd0);
            if (k == 0) check("rr_push0", 32'(bus.out_push), 32'd0);
            else        check_push("rr", (k - 1) % 4);
            if (k == 4) check("rr_active", 32'(fsm_state), 32'(ST_ACTIVE));
        end

        // VC1 backpressured: grants alternate VC0 / VC2
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus.fifo_empty       = 4'b1000;
            bus.dest_almost_full = 4'b0010;
            #1;
            check("bp_pop", 32'(bus.fifo_pop), (k % 2 == 0) ? 32'h1 : 32'h4);
            if (k == 0) check("bp_push0", 32'(bus.out_push), 32'd0);
            else        check_push("bp", (k % 2 == 1) ? 0 : 2);
        end
        @(negedge clk);
        bus.fifo_empty       = 4'hF;
        bus.dest_almost_full = 4'h0;
        #1;
        check("bp_tail_pop", 32'(bus.fifo_pop), 32'd0);
        check_push("bp_tail", 2);
        @(negedge clk); #1;
        check("bp_idle_push", 32'(bus.out_push), 32'd0);
        check("bp_idle_state", 32'(fsm_state), 32'(ST_IDLE));
`endif

        // single word in VC3
        @(negedge clk); bus.fifo_empty = 4'b0111; #1;
        check("v3_pop", 32'(bus.fifo_pop), 32'h8);
        @(negedge clk); bus.fifo_empty = 4'hF; #1;
        check("v3_pop_after", 32'(bus.fifo_pop), 32'h0);
        check("v3_state", 32'(fsm_state), 32'(ST_ACTIVE));
        check_push("v3", 3);
        @(negedge clk); #1;
        check("v3_push_once", 32'(bus.out_push), 32'd0);
        check("v3_idle_state", 32'(fsm_state), 32'(ST_IDLE));
        check("v3_idle", 32'(idle), 32'd1);

        // init asserted in ACTIVE while a pop is in flight
        @(negedge clk);
        bus.fifo_empty = 4'h0;
        umbral_sup_in  = 3'd6;
        umbral_inf_in  = 3'd2;
        #1;
        check("ini_pop_a", 32'(bus.fifo_pop), 32'h1);
        @(negedge clk); init = 1'b1; #1;
        check("ini_state_b", 32'(fsm_state), 32'(ST_ACTIVE));
        check("ini_pop_b", 32'(bus.fifo_pop), 32'(INIT_POP_B));
        check("ini_push_b", 32'(bus.out_push), 32'd0);
        @(negedge clk); #1;
        check("ini_state_c", 32'(fsm_state), 32'(ST_INIT));
        check("ini_fs_c", 32'(fifo_state), 32'd0);
        check("ini_push_c", 32'(bus.out_push), 32'd0);
        check("ini_pop_c", 32'(bus.fifo_pop), 32'd0);
        check("ini_sup_hold", 32'(umbral_superior), 32'd5);
        @(negedge clk); init = 1'b0; bus.fifo_empty = 4'hF; #1;
        check("ini_sup", 32'(umbral_superior), 32'd6);
        check("ini_inf", 32'(umbral_inferior), 32'd2);
        @(negedge clk); #1;
        check("ini_back_idle", 32'(fsm_state), 32'(ST_IDLE));
        check("ini_fs_e", 32'(fifo_state), 32'd1);

        // reset mid-operation drops in-flight data
        @(negedge clk); bus.fifo_empty = 4'h0; #1;
        check("mr_pop", 32'(bus.fifo_pop), 32'(RST_POP));
        @(negedge clk); reset = 1'b1; #1;
        check_push("mr_pending", RST_VC);
        @(negedge clk); #1;
        check("mr_state", 32'(fsm_state), 32'(ST_RESET));
        check("mr_push", 32'(bus.out_push), 32'd0);
        check("mr_pop0", 32'(bus.fifo_pop), 32'd0);
        check("mr_vc", 32'(bus.out_vc), 32'd0);
        check("mr_sup", 32'(umbral_superior), 32'd0);
        check("mr_fs", 32'(fifo_state), 32'd0);

        @(negedge clk); reset = 1'b0; bus.fifo_empty = 4'hF;
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
